rr_mux4_arbiter: RTL and testbench
==================================

Name: rr_mux4_arbiter

Overview:
Round-robin arbiter that shares one 4:1 single-bit mux between four requesters. It owns the mux select: it grants one requester at a time, drives sel[1:0], and gates the mux output. Grants are held while the requester keeps asking, up to a hold limit, so no requester can starve the others. It sits in front of the team's mux4to1 cell in the lab datapath.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles one grant may be held (legal range 1..255).

Ports:
clk     input   1  rising-edge clock
rst     input   1  synchronous, active-high reset
req     input   4  request per requester; req[k] asks for the mux
i       input   4  data bit per requester; i[k] is the mux input k
gnt     output  4  one-hot grant, registered; 4'b0000 when idle
sel     output  2  registered mux select = index of the granted requester
busy    output  1  registered; 1 while a grant is active
y       output  1  mux output i[sel] when busy, else 0 (combinational from registered sel/busy)

Behaviour:
- Reset: synchronous on clk while rst=1. Values: state=IDLE, gnt=0, sel=0, busy=0, ptr=0, cnt=0. y=0 because busy=0. Reset asserted mid-grant drops the grant on that same edge.
- pick(req, start): the first index k in the order start, start+1, ... (mod 4) with req[k]=1.
- ptr (2-bit) is the round-robin start point.
- IDLE:
  - If req≠0: next edge gnt<=onehot(pick(req,ptr)), sel<=that index, cnt<=1, busy<=1, state<=GRANT.
  - Latency from req rise to gnt is exactly 1 cycle.
  - If req=0: all outputs hold. sel keeps its last value; y=0.
- GRANT, release condition rel = (req[sel]==0) || (cnt==HOLD_MAX):
  - rel=0: cnt<=cnt+1. gnt and sel hold.
  - rel=1: ptr<=sel+1 (mod 4, wraps 3->0).
    - If req≠0: same-edge handover. gnt<=onehot(pick(req,sel+1)), sel updated, cnt<=1, stay in GRANT. No dead cycle.
    - If req=0: gnt<=0, busy<=0, state<=IDLE.
  - On HOLD_MAX expiry with only the current holder requesting, pick wraps back to the same index. The holder is re-granted with cnt=1 and no gap.
- cnt width: clog2(HOLD_MAX+1). It never exceeds HOLD_MAX.
- HOLD_MAX=1: re-arbitration every cycle; strict rotation among the active requesters.
- gnt is always one-hot or zero. gnt=onehot(sel) whenever busy=1.
- y=i[sel] combinationally while busy=1. The arbiter imposes no data latency.
- A requester dropping req is seen on the edge where req[sel]=0 is sampled. That is the cycle after the last cycle it needed the mux.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,... each for HOLD_MAX cycles.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, GRANT=1'b1), N_REQ=4, SEL_W=2.
- Sub-module rr_pick4: combinational (req[3:0], start[1:0]) -> (any, idx[1:0]).
- The data path instantiates the existing mux4to1 cell with sel and i. y is that output ANDed with busy.

Test Plan:
1. rst=1 for 2 cycles, req=4'b1111 -> gnt=0, sel=0, busy=0, y=0 throughout reset. First edge after release gives gnt=4'b0001.
2. HOLD_MAX=8, req=4'b0100 held 3 cycles then 0; i=4'b0100 -> gnt=4'b0100 and sel=2 one cycle after req, y=1 while busy. Return to IDLE, gnt=0, ptr=3.
3. HOLD_MAX=2, req=4'b1111 constant -> grant order 0,0,1,1,2,2,3,3,0,... with no idle cycles. sel follows 0,0,1,1,2,2,3,3.
4. HOLD_MAX=3, req=4'b1000 constant -> gnt=4'b1000 continuous; cnt cycles 1,2,3,1; busy never drops.
5. Holder 1 drops req while req=4'b1101 -> next edge gnt=4'b0100 (pick from 2), sel=2. i=4'b0101 gives y=1.
6. Assert rst for 1 cycle mid-grant (sel=3) -> next edge gnt=0, busy=0, ptr=0. Then req=4'b1010 gives gnt=4'b0010.

Source files
------------

// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
package rr_mux4_arbiter_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Requester-side bundle of the arbiter: requests, data bits, grant and muxed output.
interface rr_mux4_arbiter_if;
    import rr_mux4_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] i;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             y;

    modport master (output req, i, input gnt, sel, busy, y);
    modport slave  (input req, i, output gnt, sel, busy, y);
endinterface

// File: rtl/mux4to1.sv
// Single-bit 4:1 mux cell of the lab datapath.
module mux4to1 (
    input  logic [3:0] i,
    input  logic [1:0] sel,
    output logic       y
);
    assign y = i[sel];
endmodule

// File: rtl/rr_pick4.sv
// First requester at or after start, scanning upward with wrap.
module rr_pick4
    import rr_mux4_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    always_comb begin
        logic [SEL_W-1:0] j;
        any = 1'b0;
        idx = start;
        j   = start;
        // Scan farthest offset first so the nearest hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = start + SEL_W'(k);
            if (req[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin owner of a shared 4:1 mux: grants one requester, drives sel, gates y.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    rr_mux4_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_q, gnt_nxt;
    logic [SEL_W-1:0] sel_q, sel_nxt;
    logic [SEL_W-1:0] ptr_q, ptr_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             busy_q, busy_nxt;

    logic [SEL_W-1:0] sel_inc, pick_start, pick_idx;
    logic             pick_any, rel, mux_y;

    assign sel_inc    = sel_q + SEL_W'(1);
    // A releasing holder restarts the search just past itself, so it can only win again if alone.
    assign pick_start = (state == IDLE) ? ptr_q : sel_inc;
    assign rel        = !bus.req[sel_q] || (cnt_q == CNT_W'(HOLD_MAX));

    rr_pick4 u_pick (
        .req   (bus.req),
        .start (pick_start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= '0;
            sel_q  <= '0;
            busy_q <= 1'b0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            gnt_q  <= gnt_nxt;
            sel_q  <= sel_nxt;
            busy_q <= busy_nxt;
            ptr_q  <= ptr_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any)         state_nxt = GRANT;
            GRANT:   if (rel && !pick_any) state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt  = gnt_q;
        sel_nxt  = sel_q;
        busy_nxt = busy_q;
        ptr_nxt  = ptr_q;
        cnt_nxt  = cnt_q;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_nxt  = onehot(pick_idx);
                    sel_nxt  = pick_idx;
                    busy_nxt = 1'b1;
                    cnt_nxt  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!rel) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end else begin
                    ptr_nxt = sel_inc;
                    if (pick_any) begin
                        gnt_nxt = onehot(pick_idx);
                        sel_nxt = pick_idx;
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        gnt_nxt  = '0;
                        busy_nxt = 1'b0;
                    end
                end
            end
            default: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
            end
        endcase
    end

    mux4to1 u_mux (
        .i   (bus.i),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.y    = mux_y & busy_q;
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench: three arbiters (HOLD_MAX 8, 2, 3) on a shared clock and reset.
module tb_rr_mux4_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_mux4_arbiter_if b8 ();
    rr_mux4_arbiter_if b2 ();
    rr_mux4_arbiter_if b3 ();

    rr_mux4_arbiter #(.HOLD_MAX(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
    rr_mux4_arbiter #(.HOLD_MAX(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    rr_mux4_arbiter #(.HOLD_MAX(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int es[9];
        es = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

        rst    = 1'b1;
        b8.req = 4'b1111; b8.i = 4'b1111;
        b2.req = 4'b0000; b2.i = 4'b0000;
        b3.req = 4'b0000; b3.i = 4'b0000;

        // reset holds everything low even with all requesting
        for (int c = 0; c < 2; c++) begin
            tick;
            chk("rst_gnt",  b8.gnt,  4'b0000);
            chk("rst_sel",  b8.sel,  2'd0);
            chk("rst_busy", b8.busy, 1'b0);
            chk("rst_y",    b8.y,    1'b0);
        end
        rst = 1'b0;
        tick;
        chk("rel_gnt",  b8.gnt,  4'b0001);
        chk("rel_sel",  b8.sel,  2'd0);
        chk("rel_busy", b8.busy, 1'b1);
        b8.req = 4'b0000;
        tick;
        chk("rel_idle_gnt",  b8.gnt,  4'b0000);
        chk("rel_idle_busy", b8.busy, 1'b0);

        // single requester 2 for 3 cycles
        b8.req = 4'b0100; b8.i = 4'b0100;
        tick;
        chk("t2_gnt",  b8.gnt,  4'b0100);
        chk("t2_sel",  b8.sel,  2'd2);
        chk("t2_busy", b8.busy, 1'b1);
        chk("t2_y",    b8.y,    1'b1);
        for (int c = 0; c < 2; c++) begin
            tick;
            chk("t2_hold_gnt", b8.gnt, 4'b0100);
            chk("t2_hold_y",   b8.y,   1'b1);
        end
        b8.req = 4'b0000;
        tick;
        chk("t2_idle_gnt",  b8.gnt,  4'b0000);
        chk("t2_idle_busy", b8.busy, 1'b0);
        chk("t2_idle_y",    b8.y,    1'b0);
        chk("t2_idle_sel",  b8.sel,  2'd2);
        b8.req = 4'b1111;
        tick;
        chk("t2_ptr3_gnt", b8.gnt, 4'b1000);
        chk("t2_ptr3_sel", b8.sel, 2'd3);
        b8.req = 4'b0000;
        tick;
        chk("t2_ptr3_idle", b8.busy, 1'b0);

        // HOLD_MAX=2 rotation with all requesting
        b2.req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick;
            chk("t3_sel",  b2.sel,  es[k]);
            chk("t3_gnt",  b2.gnt,  32'd1 << es[k]);
            chk("t3_busy", b2.busy, 1'b1);
        end
        b2.req = 4'b0000;
        tick;
        chk("t3_idle", b2.busy, 1'b0);

        // HOLD_MAX=3 lone holder re-granted without a gap
        b3.req = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk("t4_gnt",  b3.gnt,  4'b1000);
            chk("t4_busy", b3.busy, 1'b1);
        end
        b3.req = 4'b0000;
        tick;
        chk("t4_idle", b3.busy, 1'b0);

        // holder 1 drops while 3,2,0 wait: handover to 2
        b8.req = 4'b0010;
        tick;
        chk("t5_gnt1", b8.gnt, 4'b0010);
        b8.req = 4'b1101; b8.i = 4'b0101;
        tick;
        chk("t5_gnt", b8.gnt,  4'b0100);
        chk("t5_sel", b8.sel,  2'd2);
        chk("t5_y",   b8.y,    1'b1);
        b8.i = 4'b0001;
        #1;
        chk("t5_y_comb", b8.y, 1'b0);
        b8.req = 4'b0000;
        tick;
        chk("t5_idle", b8.busy, 1'b0);

        // reset mid-grant with sel=3, then ptr must restart at 0
        b8.req = 4'b1000;
        tick;
        chk("t6_sel3", b8.sel, 2'd3);
        rst = 1'b1;
        tick;
        chk("t6_rst_gnt",  b8.gnt,  4'b0000);
        chk("t6_rst_busy", b8.busy, 1'b0);
        chk("t6_rst_sel",  b8.sel,  2'd0);
        chk("t6_rst_y",    b8.y,    1'b0);
        rst = 1'b0;
        b8.req = 4'b1010;
        tick;
        chk("t6_gnt", b8.gnt, 4'b0010);
        chk("t6_sel", b8.sel, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
